// File: rtl/alu_pkg.sv
// Shared encodings for the EX-stage ALU control unit: ALU control codes, aluop classes,
// R-type funct values, mult/div op codes, HI/LO read selects and the ID-stage decoder.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_XOR  = 4'b0011,
    ALU_NOR  = 4'b0100,
    ALU_SLL  = 4'b0101,
    ALU_SUB  = 4'b0110,
    ALU_SLT  = 4'b0111,
    ALU_SRL  = 4'b1000,
    ALU_SRA  = 4'b1001,
    ALU_SLTU = 4'b1010,
    ALU_NOP  = 4'b1111
  } alu_ctrl_e;

  typedef enum logic [2:0] {
    AOP_ADD   = 3'b000,
    AOP_SUB   = 3'b001,
    AOP_FUNCT = 3'b010,
    AOP_AND   = 3'b011,
    AOP_OR    = 3'b100,
    AOP_SLT   = 3'b101,
    AOP_XOR   = 3'b110,
    AOP_ILL   = 3'b111
  } aluop_e;

  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_SRA   = 6'b000011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_ADDU  = 6'b100001;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SUBU  = 6'b100011;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  localparam logic [1:0] HILO_NONE = 2'b00;
  localparam logic [1:0] HILO_LO   = 2'b01;
  localparam logic [1:0] HILO_HI   = 2'b10;

  typedef struct packed {
    alu_ctrl_e  ctrl;
    logic       illegal;
    logic       is_md;
    logic [1:0] md_op;
    logic [1:0] hilo;
  } dec_t;

  function automatic dec_t alu_decode(input logic [2:0] aluop, input logic [5:0] funct);
    dec_t d;
    d = '{ctrl: ALU_NOP, illegal: 1'b0, is_md: 1'b0, md_op: MD_MULT, hilo: HILO_NONE};
    case (aluop_e'(aluop))
      AOP_ADD: d.ctrl = ALU_ADD;
      AOP_SUB: d.ctrl = ALU_SUB;
      AOP_AND: d.ctrl = ALU_AND;
      AOP_OR:  d.ctrl = ALU_OR;
      AOP_SLT: d.ctrl = ALU_SLT;
      AOP_XOR: d.ctrl = ALU_XOR;
      AOP_FUNCT: begin
        case (funct)
          F_ADD, F_ADDU: d.ctrl = ALU_ADD;
          F_SUB, F_SUBU: d.ctrl = ALU_SUB;
          F_AND:   d.ctrl = ALU_AND;
          F_OR:    d.ctrl = ALU_OR;
          F_XOR:   d.ctrl = ALU_XOR;
          F_NOR:   d.ctrl = ALU_NOR;
          F_SLT:   d.ctrl = ALU_SLT;
          F_SLTU:  d.ctrl = ALU_SLTU;
          F_SLL:   d.ctrl = ALU_SLL;
          F_SRL:   d.ctrl = ALU_SRL;
          F_SRA:   d.ctrl = ALU_SRA;
          F_MULT:  begin d.is_md = 1'b1; d.md_op = MD_MULT;  end
          F_MULTU: begin d.is_md = 1'b1; d.md_op = MD_MULTU; end
          F_DIV:   begin d.is_md = 1'b1; d.md_op = MD_DIV;   end
          F_DIVU:  begin d.is_md = 1'b1; d.md_op = MD_DIVU;  end
          F_MFHI:  d.hilo = HILO_HI;
          F_MFLO:  d.hilo = HILO_LO;
          default: d.illegal = 1'b1;
        endcase
      end
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/md_sequencer.sv
// Mult/div occupancy tracker: busy rises the cycle after start and stays high for exactly
// MUL_LAT or DIV_LAT cycles; no backpressure, the caller only starts when idle or on the last cycle.
module md_sequencer #(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic div_sel,
  output logic busy,
  output logic last
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] lat_m1;

  assign lat_m1 = div_sel ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
  assign busy   = (state == ST_RUN);
  assign last   = busy && (cnt == '0);

  // A start on the final busy cycle reloads directly so back-to-back ops leave no gap.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_RUN;
            cnt   <= lat_m1;
          end
        end
        default: begin
          if (cnt == '0) begin
            if (start) begin
              cnt <= lat_m1;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/alu_ctrl_pipe.sv
// ID->EX ALU control decode register, 1-cycle latency; ex_stall holds EX and blocks ID,
// HI/LO-dependent instructions also wait while a mult/div is in flight (released on its last cycle).
module alu_ctrl_pipe
  import alu_pkg::*;
#(
  parameter int CTRL_W  = 4,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [2:0]        aluop,
  input  logic [5:0]        funct,
  input  logic              flush,
  input  logic              ex_stall,
  output logic              ex_valid,
  output logic [CTRL_W-1:0] alucontrol,
  output logic              illegal,
  output logic              md_start,
  output logic [1:0]        md_op,
  output logic              md_busy,
  output logic [1:0]        hilo_rd
);

  dec_t dec;
  logic hilo_class;
  logic md_last;
  logic capture;

  assign dec        = alu_decode(aluop, funct);
  assign hilo_class = dec.is_md || (dec.hilo != HILO_NONE);
  // The busy cycle that ends the current op already frees HI/LO for the next dependent.
  assign id_ready   = !ex_stall && !(hilo_class && md_busy && !md_last);
  assign capture    = id_valid && id_ready && !flush;

  md_sequencer #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) u_md_sequencer (
    .clk     (clk),
    .reset   (reset),
    .start   (capture && dec.is_md),
    .div_sel (dec.md_op[1]),
    .busy    (md_busy),
    .last    (md_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid   <= 1'b0;
      alucontrol <= CTRL_W'(ALU_NOP);
      illegal    <= 1'b0;
      md_start   <= 1'b0;
      md_op      <= MD_MULT;
      hilo_rd    <= HILO_NONE;
    end else if (capture) begin
      ex_valid   <= 1'b1;
      alucontrol <= CTRL_W'(dec.ctrl);
      illegal    <= dec.illegal;
      md_start   <= dec.is_md;
      md_op      <= dec.md_op;
      hilo_rd    <= dec.hilo;
    end else if (!ex_stall) begin
      ex_valid   <= 1'b0;
      alucontrol <= CTRL_W'(ALU_NOP);
      illegal    <= 1'b0;
      md_start   <= 1'b0;
      md_op      <= MD_MULT;
      hilo_rd    <= HILO_NONE;
    end else begin
      md_start   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_ctrl_pipe.sv
// Directed bench for alu_ctrl_pipe with an expected-EX-word scoreboard and a busy-cycle model.
module tb_alu_ctrl_pipe;

  localparam int CTRL_W  = 4;
  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 32;

  typedef struct packed {
    logic       vld;
    logic [3:0] ctrl;
    logic       ill;
    logic       start;
    logic [1:0] mop;
    logic [1:0] hilo;
  } ex_t;

  localparam ex_t BUBBLE = '{vld: 1'b0, ctrl: 4'hF, default: '0};

  logic clk = 1'b0;
  logic reset, id_valid, flush, ex_stall;
  logic [2:0] aluop;
  logic [5:0] funct;
  logic id_ready, ex_valid, illegal, md_start, md_busy;
  logic [CTRL_W-1:0] alucontrol;
  logic [1:0] md_op, hilo_rd;

  int n_cmp = 0;
  int n_fail = 0;
  int busy_left = 0;
  int busy_seen = 0;
  logic last_cap;
  ex_t last_ex;
  ex_t sb[$];

  always #5 clk = ~clk;

  alu_ctrl_pipe #(.CTRL_W(CTRL_W), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_ready(id_ready),
    .aluop(aluop), .funct(funct), .flush(flush), .ex_stall(ex_stall),
    .ex_valid(ex_valid), .alucontrol(alucontrol), .illegal(illegal),
    .md_start(md_start), .md_op(md_op), .md_busy(md_busy), .hilo_rd(hilo_rd)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic ex_t ref_dec(input logic [2:0] op, input logic [5:0] fn);
    ex_t r;
    r = '{vld: 1'b1, ctrl: 4'hF, default: '0};
    if (op != 3'b010) begin
      case (op)
        3'd0: r.ctrl = 4'h2;
        3'd1: r.ctrl = 4'h6;
        3'd3: r.ctrl = 4'h0;
        3'd4: r.ctrl = 4'h1;
        3'd5: r.ctrl = 4'h7;
        3'd6: r.ctrl = 4'h3;
        default: r.ill = 1'b1;
      endcase
    end else if (fn[5:2] == 4'b0110) begin
      r.start = 1'b1;
      r.mop = fn[1:0];
    end else begin
      case (fn)
        6'h20, 6'h21: r.ctrl = 4'h2;
        6'h22, 6'h23: r.ctrl = 4'h6;
        6'h24: r.ctrl = 4'h0;
        6'h25: r.ctrl = 4'h1;
        6'h26: r.ctrl = 4'h3;
        6'h27: r.ctrl = 4'h4;
        6'h2A: r.ctrl = 4'h7;
        6'h2B: r.ctrl = 4'hA;
        6'h00: r.ctrl = 4'h5;
        6'h02: r.ctrl = 4'h8;
        6'h03: r.ctrl = 4'h9;
        6'h10: r.hilo = 2'b10;
        6'h12: r.hilo = 2'b01;
        default: r.ill = 1'b1;
      endcase
    end
    return r;
  endfunction

  function automatic ex_t observed();
    return ex_t'({ex_valid, alucontrol, illegal, md_start, md_op, hilo_rd});
  endfunction

  // One cycle: drive ID, check id_ready, push the expected EX word, clock, pop and compare.
  task automatic issue(input string tag, input logic v, input logic [2:0] op,
                       input logic [5:0] fn, input logic fl, input logic st);
    ex_t d, e, got;
    logic hc, rdy, cap;
    d   = ref_dec(op, fn);
    hc  = d.start || (d.hilo != 2'b00);
    rdy = !st && !(hc && busy_left > 1);
    cap = v && rdy && !fl;
    id_valid = v; aluop = op; funct = fn; flush = fl; ex_stall = st;
    #1;
    chk({tag, "_rdy"}, 16'(id_ready), 16'(rdy));
    if (cap) e = d;
    else if (!st) e = BUBBLE;
    else begin e = last_ex; e.start = 1'b0; end
    sb.push_back(e);
    @(posedge clk); #1;
    if (busy_left > 0) busy_left--;
    if (cap && d.start) busy_left = d.mop[1] ? DIV_LAT : MUL_LAT;
    e = sb.pop_front();
    got = observed();
    chk({tag, "_ex"}, 16'(got), 16'(e));
    chk({tag, "_busy"}, 16'(md_busy), 16'(busy_left > 0));
    if (md_busy) busy_seen++;
    last_ex = e;
    last_cap = cap;
    id_valid = 1'b0; flush = 1'b0; ex_stall = 1'b0;
  endtask

  task automatic do_reset(input int n);
    ex_t got;
    reset = 1'b1; id_valid = 1'b1; aluop = 3'b000; funct = 6'h20; flush = 1'b0; ex_stall = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      got = observed();
      chk("rst_ex", 16'(got), 16'(BUBBLE));
      chk("rst_busy", 16'(md_busy), 16'(0));
    end
    reset = 1'b0; id_valid = 1'b0;
    busy_left = 0;
    last_ex = BUBBLE;
  endtask

  initial begin
    int rejects;
    do_reset(3);

    // R-type back-to-back: NOR, SRA, SLTU
    issue("nor", 1, 3'b010, 6'h27, 0, 0);
    issue("sra", 1, 3'b010, 6'h03, 0, 0);
    issue("sltu", 1, 3'b010, 6'h2B, 0, 0);
    // aluop classes and remaining funct codes
    issue("aop_add", 1, 3'b000, 6'h3F, 0, 0);
    issue("aop_sub", 1, 3'b001, 6'h00, 0, 0);
    issue("aop_and", 1, 3'b011, 6'h00, 0, 0);
    issue("aop_or", 1, 3'b100, 6'h00, 0, 0);
    issue("aop_slt", 1, 3'b101, 6'h00, 0, 0);
    issue("aop_xor", 1, 3'b110, 6'h00, 0, 0);
    issue("addu", 1, 3'b010, 6'h21, 0, 0);
    issue("subu", 1, 3'b010, 6'h23, 0, 0);
    issue("sll", 1, 3'b010, 6'h00, 0, 0);
    issue("srl", 1, 3'b010, 6'h02, 0, 0);
    issue("idle", 0, 3'b010, 6'h20, 0, 0);

    // Illegal encodings
    issue("ill_aop", 1, 3'b111, 6'h20, 0, 0);
    issue("ill_fn", 1, 3'b010, 6'h3F, 0, 0);

    // DIV with an independent ADD following while busy
    busy_seen = 0;
    issue("div", 1, 3'b010, 6'h1A, 0, 0);
    issue("add_busy", 1, 3'b010, 6'h20, 0, 0);
    for (int i = 0; i < 36; i++) issue("div_wait", 0, 3'b000, 6'h00, 0, 0);
    chk("div_busy_len", 16'(busy_seen), 16'(DIV_LAT));

    // MULT then MFLO held in ID
    issue("mult", 1, 3'b010, 6'h18, 0, 0);
    rejects = 0;
    last_cap = 1'b0;
    for (int i = 0; i < 10 && !last_cap; i++) begin
      issue("mflo", 1, 3'b010, 6'h12, 0, 0);
      if (!last_cap) rejects++;
    end
    chk("mflo_taken", 16'(last_cap), 16'(1));
    chk("mflo_wait", 16'(rejects), 16'(MUL_LAT - 1));
    for (int i = 0; i < 4; i++) issue("mflo_idle", 0, 3'b000, 6'h00, 0, 0);

    // Back-to-back MULTs: no gap in md_busy
    busy_seen = 0;
    issue("mult_a", 1, 3'b010, 6'h18, 0, 0);
    last_cap = 1'b0;
    for (int i = 0; i < 10 && !last_cap; i++) issue("mult_b", 1, 3'b010, 6'h18, 0, 0);
    for (int i = 0; i < 8; i++) issue("b2b_idle", 0, 3'b000, 6'h00, 0, 0);
    chk("b2b_busy_len", 16'(busy_seen), 16'(2 * MUL_LAT));

    // Flush kills a MULT in ID
    issue("flush_mult", 1, 3'b010, 6'h18, 1, 0);
    issue("flush_after", 0, 3'b000, 6'h00, 0, 0);

    // Stall holds EX and suppresses a second md_start; flush+stall does not consume
    issue("multu", 1, 3'b010, 6'h19, 0, 0);
    issue("stall_hold", 1, 3'b000, 6'h00, 0, 1);
    issue("stall_flush", 1, 3'b010, 6'h18, 1, 1);
    for (int i = 0; i < 4; i++) issue("multu_wait", 0, 3'b000, 6'h00, 0, 0);
    issue("divu", 1, 3'b010, 6'h1B, 0, 0);
    issue("mfhi_blk", 1, 3'b010, 6'h10, 0, 0);
    issue("divu_run", 0, 3'b000, 6'h00, 0, 0);

    // Reset aborts a DIVU in flight
    do_reset(1);
    issue("post_rst", 1, 3'b010, 6'h10, 0, 0);
    issue("post_idle", 0, 3'b000, 6'h00, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
